// File: rtl/seg_pio_arbiter.sv
// -----------------------------------------------------------------------------
// seg_pio_arbiter
//
// Two requesters share one seven-segment PIO reached over Avalon-MM. Each
// accepted hex byte is decoded into two active-low seven-segment digits
// ({g,f,e,d,c,b,a} per digit) and written to the PIO as a single one-cycle
// write strobe. A requester is granted round-robin. If no requester writes
// for BLANK_CYCLES cycles, the display is blanked once with 14'h3FFF.
//
// Parameters
//   BLANK_CYCLES   idle cycles after the last requester write before the
//                  automatic blank write; 0 disables auto-blank.
//
// Ports
//   clk            rising-edge clock for all state
//   reset          synchronous active-high reset
//   req_valid[1:0] bit i: requester i holds a byte to display
//   req_data0/1    byte from requester 0 / 1 (sampled in the ready cycle)
//   req_ready[1:0] combinational one-cycle accept pulse per requester
//   avm_address    Avalon-MM address (always 0, single data register)
//   avm_chipselect Avalon-MM chipselect, high only in the write cycle
//   avm_write_n    Avalon-MM active-low write, low only in the write cycle
//   avm_writedata  {18'b0, seg} in the write cycle, 0 otherwise
//   busy           high while the write strobe is on the bus
//   seg_shadow     copy of the last value written to the PIO
// -----------------------------------------------------------------------------
module seg_pio_arbiter #(
    parameter int unsigned BLANK_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [7:0]  req_data0,
    input  logic [7:0]  req_data1,
    output logic [1:0]  req_ready,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    output logic        busy,
    output logic [13:0] seg_shadow
);

    localparam logic [31:0] BLANK_LIMIT = 32'(BLANK_CYCLES);
    localparam logic [13:0] SEG_BLANK   = 14'h3FFF;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    // Active-low segment pattern for one hex nibble, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode_nibble(input logic [3:0] nibble);
        logic [6:0] pattern;
        case (nibble)
            4'h0:    pattern = 7'h40;
            4'h1:    pattern = 7'h79;
            4'h2:    pattern = 7'h24;
            4'h3:    pattern = 7'h30;
            4'h4:    pattern = 7'h19;
            4'h5:    pattern = 7'h12;
            4'h6:    pattern = 7'h02;
            4'h7:    pattern = 7'h78;
            4'h8:    pattern = 7'h00;
            4'h9:    pattern = 7'h10;
            4'hA:    pattern = 7'h08;
            4'hB:    pattern = 7'h03;
            4'hC:    pattern = 7'h46;
            4'hD:    pattern = 7'h21;
            4'hE:    pattern = 7'h06;
            4'hF:    pattern = 7'h0E;
            default: pattern = 7'h7F;
        endcase
        return pattern;
    endfunction

    // High nibble drives the upper digit seg[13:7], low nibble seg[6:0].
    function automatic logic [13:0] decode_byte(input logic [7:0] data);
        return {decode_nibble(data[7:4]), decode_nibble(data[3:0])};
    endfunction

    // One-hot grant; with both valid the requester not granted last wins.
    function automatic logic [1:0] arbitrate(input logic [1:0] valid,
                                             input logic       last_grant);
        logic [1:0] grant;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        return grant;
    endfunction

    state_t      state_r;
    logic        last_grant_r;
    logic [13:0] seg_r;
    logic        blank_write_r;
    logic [31:0] timer_r;
    logic [13:0] shadow_r;
    logic        chipselect_r;
    logic        write_n_r;
    logic [31:0] writedata_r;
    logic        busy_r;

    logic [1:0]  grant_s;
    logic [13:0] grant_seg_s;
    logic        blank_go_s;
    logic [31:0] timer_inc_s;

    // Grant, decoded data and blank decision for the current IDLE cycle.
    always_comb begin
        grant_s     = 2'b00;
        grant_seg_s = 14'h0000;
        blank_go_s  = 1'b0;
        timer_inc_s = timer_r;
        if (!reset && (state_r == IDLE)) begin
            grant_s = arbitrate(req_valid, last_grant_r);
        end else begin
            grant_s = 2'b00;
        end
        if (grant_s[1]) begin
            grant_seg_s = decode_byte(req_data1);
        end else begin
            grant_seg_s = decode_byte(req_data0);
        end
        // The blank only fires on a quiet bus and only once per requester
        // write: after it the shadow already holds the blank pattern, which
        // no decoded byte can ever produce.
        if ((BLANK_LIMIT != 32'd0) && (timer_r == BLANK_LIMIT) &&
            (state_r == IDLE) && (req_valid == 2'b00) &&
            (shadow_r != SEG_BLANK)) begin
            blank_go_s = 1'b1;
        end else begin
            blank_go_s = 1'b0;
        end
        if (timer_r < BLANK_LIMIT) begin
            timer_inc_s = timer_r + 32'd1;
        end else begin
            timer_inc_s = timer_r;
        end
    end

    // Two-state write FSM with registered bus outputs, shadow and idle timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            last_grant_r  <= 1'b1;
            seg_r         <= SEG_BLANK;
            blank_write_r <= 1'b0;
            timer_r       <= 32'd0;
            shadow_r      <= SEG_BLANK;
            chipselect_r  <= 1'b0;
            write_n_r     <= 1'b1;
            writedata_r   <= 32'd0;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    timer_r <= timer_inc_s;
                    if (grant_s != 2'b00) begin
                        // Requester wins over a coinciding blank condition.
                        state_r       <= WRITE;
                        last_grant_r  <= grant_s[1];
                        seg_r         <= grant_seg_s;
                        blank_write_r <= 1'b0;
                        chipselect_r  <= 1'b1;
                        write_n_r     <= 1'b0;
                        writedata_r   <= {18'd0, grant_seg_s};
                        busy_r        <= 1'b1;
                    end else if (blank_go_s) begin
                        state_r       <= WRITE;
                        seg_r         <= SEG_BLANK;
                        blank_write_r <= 1'b1;
                        chipselect_r  <= 1'b1;
                        write_n_r     <= 1'b0;
                        writedata_r   <= {18'd0, SEG_BLANK};
                        busy_r        <= 1'b1;
                    end else begin
                        state_r       <= IDLE;
                        chipselect_r  <= 1'b0;
                        write_n_r     <= 1'b1;
                        writedata_r   <= 32'd0;
                        busy_r        <= 1'b0;
                    end
                end
                WRITE: begin
                    state_r      <= IDLE;
                    shadow_r     <= seg_r;
                    chipselect_r <= 1'b0;
                    write_n_r    <= 1'b1;
                    writedata_r  <= 32'd0;
                    busy_r       <= 1'b0;
                    // Only requester writes restart the idle timer; a blank
                    // write lets it keep counting (it stays saturated).
                    if (blank_write_r) begin
                        timer_r <= timer_inc_s;
                    end else begin
                        timer_r <= 32'd0;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    chipselect_r <= 1'b0;
                    write_n_r    <= 1'b1;
                    writedata_r  <= 32'd0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    // The PIO has a single data register at offset 0.
    assign avm_address    = 2'b00;
    assign req_ready      = grant_s;
    assign avm_chipselect = chipselect_r;
    assign avm_write_n    = write_n_r;
    assign avm_writedata  = writedata_r;
    assign busy           = busy_r;
    assign seg_shadow     = shadow_r;

endmodule

// File: tb/tb_seg_pio_arbiter.sv
// -----------------------------------------------------------------------------
// tb_seg_pio_arbiter
//
// Drives one BLANK_CYCLES=10 instance (checked every cycle against a
// cycle-count based reference model) and one BLANK_CYCLES=0 instance sharing
// the same inputs. Table vectors cover the full decode table, followed by
// hand-written corner sequences and a randomized traffic phase.
// -----------------------------------------------------------------------------
module tb_seg_pio_arbiter;

    localparam int B = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [7:0]  req_data0;
    logic [7:0]  req_data1;

    logic [1:0]  req_ready;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic        busy;
    logic [13:0] seg_shadow;

    logic [1:0]  z_req_ready;
    logic [1:0]  z_avm_address;
    logic        z_avm_chipselect;
    logic        z_avm_write_n;
    logic [31:0] z_avm_writedata;
    logic        z_busy;
    logic [13:0] z_seg_shadow;

    seg_pio_arbiter #(.BLANK_CYCLES(B)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .req_data0(req_data0), .req_data1(req_data1), .req_ready(req_ready),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
        .busy(busy), .seg_shadow(seg_shadow)
    );

    seg_pio_arbiter #(.BLANK_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .req_data0(req_data0), .req_data1(req_data1), .req_ready(z_req_ready),
        .avm_address(z_avm_address), .avm_chipselect(z_avm_chipselect),
        .avm_write_n(z_avm_write_n), .avm_writedata(z_avm_writedata),
        .busy(z_busy), .seg_shadow(z_seg_shadow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Outputs sampled at the falling edge of the current cycle.
    logic [1:0]  s_ready;
    logic        s_cs;
    logic        s_wn;
    logic [31:0] s_wd;
    logic        s_busy;
    logic [13:0] s_shadow;
    logic        s_zcs;

    // Reference model: digit table plus cycle-number bookkeeping.
    logic [6:0]  seg7 [16];
    bit          m_pending;
    bit          m_pend_blank;
    logic [13:0] m_pend_seg;
    logic [13:0] m_shadow;
    int          m_last;
    int          m_zero_cyc;

    typedef struct {
        logic [1:0]  valid;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic [1:0]  exp_ready;
        logic [31:0] exp_wd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [13:0] m_decode(input logic [7:0] b);
        return {seg7[b[7:4]], seg7[b[3:0]]};
    endfunction

    // One clock cycle: sample, compare with the model, advance the model,
    // then return 1 time unit after the next rising edge.
    task automatic cycle();
        int         timer;
        int         g;
        logic [1:0] e_ready;
        @(negedge clk);
        s_ready  = req_ready;
        s_cs     = avm_chipselect;
        s_wn     = avm_write_n;
        s_wd     = avm_writedata;
        s_busy   = busy;
        s_shadow = seg_shadow;
        s_zcs    = z_avm_chipselect;

        g = -1;
        e_ready = 2'b00;
        if (!reset && !m_pending) begin
            if (req_valid == 2'b11)  g = (m_last == 1) ? 0 : 1;
            else if (req_valid[0])   g = 0;
            else if (req_valid[1])   g = 1;
        end
        if (g >= 0) e_ready[g] = 1'b1;

        chk("ready",   {30'd0, s_ready}, {30'd0, e_ready});
        chk("cs",      {31'd0, s_cs},    {31'd0, m_pending});
        chk("write_n", {31'd0, s_wn},    {31'd0, !m_pending});
        chk("address", {30'd0, avm_address}, 32'd0);
        chk("wdata",   s_wd, m_pending ? {18'd0, m_pend_seg} : 32'd0);
        chk("busy",    {31'd0, s_busy},  {31'd0, m_pending});
        chk("shadow",  {18'd0, s_shadow}, {18'd0, m_shadow});

        // Idle timer = cycles since it last restarted, capped at B.
        timer = cyc - m_zero_cyc;
        if (timer > B) timer = B;

        if (reset) begin
            m_pending  = 1'b0;
            m_shadow   = 14'h3FFF;
            m_last     = 1;
            m_zero_cyc = cyc + 1;
        end else if (m_pending) begin
            m_shadow  = m_pend_seg;
            m_pending = 1'b0;
            if (!m_pend_blank) m_zero_cyc = cyc + 1;
        end else if (g >= 0) begin
            m_pending    = 1'b1;
            m_pend_blank = 1'b0;
            m_pend_seg   = m_decode(g == 0 ? req_data0 : req_data1);
            m_last       = g;
        end else if (timer == B && m_shadow != 14'h3FFF) begin
            m_pending    = 1'b1;
            m_pend_blank = 1'b1;
            m_pend_seg   = 14'h3FFF;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 2'b00;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        vec_t        tbl [12];
        logic [1:0]  rr_ready [8];
        logic [31:0] rr_wd [8];
        int          ncs;
        int          first_cs;
        int          w_cyc;
        logic [31:0] blank_wd;
        int          zc;
        int          p;

        seg7 = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        m_pending = 1'b0; m_pend_blank = 1'b0; m_pend_seg = 14'h3FFF;
        m_shadow = 14'h3FFF; m_last = 1; m_zero_cyc = 0;

        tbl[0]  = '{2'b01, 8'h3A, 8'h00, 2'b01, 32'h0000_1808};
        tbl[1]  = '{2'b01, 8'h00, 8'h00, 2'b01, 32'h0000_2040};
        tbl[2]  = '{2'b10, 8'h00, 8'hFF, 2'b10, 32'h0000_070E};
        tbl[3]  = '{2'b01, 8'h12, 8'h00, 2'b01, 32'h0000_3CA4};
        tbl[4]  = '{2'b10, 8'h00, 8'h45, 2'b10, 32'h0000_0C92};
        tbl[5]  = '{2'b01, 8'h67, 8'h00, 2'b01, 32'h0000_0178};
        tbl[6]  = '{2'b10, 8'h00, 8'h89, 2'b10, 32'h0000_0010};
        tbl[7]  = '{2'b01, 8'hBC, 8'h00, 2'b01, 32'h0000_01C6};
        tbl[8]  = '{2'b10, 8'h00, 8'hDE, 2'b10, 32'h0000_1086};
        tbl[9]  = '{2'b01, 8'hA3, 8'h00, 2'b01, 32'h0000_0430};
        tbl[10] = '{2'b10, 8'h00, 8'hF0, 2'b10, 32'h0000_0740};
        tbl[11] = '{2'b01, 8'h88, 8'h00, 2'b01, 32'h0000_0000};

        // Reset state, and no grant while reset is high even with a request.
        reset = 1'b1; req_valid = 2'b00; req_data0 = 8'h00; req_data1 = 8'h00;
        repeat (2) cycle();
        chk("rst_cs",     {31'd0, s_cs}, 32'd0);
        chk("rst_wn",     {31'd0, s_wn}, 32'd1);
        chk("rst_shadow", {18'd0, s_shadow}, 32'h0000_3FFF);
        req_valid = 2'b01; req_data0 = 8'h3A;
        cycle();
        chk("rst_no_grant", {30'd0, s_ready}, 32'd0);
        reset = 1'b0; req_valid = 2'b00;

        // Decode table: accept, strobe next cycle, shadow one cycle later.
        for (int i = 0; i < 12; i++) begin
            req_valid = tbl[i].valid; req_data0 = tbl[i].d0; req_data1 = tbl[i].d1;
            cycle();
            chk("tbl_ready", {30'd0, s_ready}, {30'd0, tbl[i].exp_ready});
            req_valid = 2'b00;
            cycle();
            chk("tbl_cs", {31'd0, s_cs}, 32'd1);
            chk("tbl_wn", {31'd0, s_wn}, 32'd0);
            chk("tbl_wd", s_wd, tbl[i].exp_wd);
            cycle();
            chk("tbl_shadow", {18'd0, s_shadow}, {18'd0, tbl[i].exp_wd[13:0]});
        end

        // Round-robin with both requesters held.
        do_reset();
        rr_ready = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        rr_wd    = '{32'h0, 32'h2040, 32'h0, 32'h070E, 32'h0, 32'h2040, 32'h0, 32'h070E};
        req_valid = 2'b11; req_data0 = 8'h00; req_data1 = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rr_ready", {30'd0, s_ready}, {30'd0, rr_ready[k]});
            chk("rr_wd", s_wd, rr_wd[k]);
        end
        req_valid = 2'b00;
        cycle();

        // Single write then idle: exactly one blank. The timer restarts the
        // cycle after the strobe, reaches B B cycles later, and the blank
        // strobe follows one cycle after that.
        do_reset();
        req_valid = 2'b01; req_data0 = 8'h88;
        cycle();
        req_valid = 2'b00;
        cycle();
        w_cyc = cyc - 1;
        chk("blk_data_cs", {31'd0, s_cs}, 32'd1);
        ncs = 0; first_cs = -1; blank_wd = 32'h0;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (s_cs) begin
                ncs++;
                if (first_cs < 0) begin
                    first_cs = cyc - 1 - w_cyc;
                    blank_wd = s_wd;
                end
            end
        end
        chk("blk_count",  ncs, 32'd1);
        chk("blk_offset", first_cs, B + 2);
        chk("blk_wd",     blank_wd, 32'h0000_3FFF);
        chk("blk_shadow", {18'd0, s_shadow}, 32'h0000_3FFF);

        // Requester arriving exactly when the timer hits B wins the bus.
        do_reset();
        req_valid = 2'b01; req_data0 = 8'h3A;
        cycle();
        req_valid = 2'b00;
        cycle();
        repeat (B) cycle();
        req_valid = 2'b10; req_data1 = 8'h45;
        cycle();
        chk("coinc_ready", {30'd0, s_ready}, 32'd2);
        req_valid = 2'b00;
        cycle();
        chk("coinc_wd", s_wd, 32'h0000_0C92);
        cycle();
        chk("coinc_cs_after", {31'd0, s_cs}, 32'd0);
        chk("coinc_shadow", {18'd0, s_shadow}, 32'h0000_0C92);

        // Reset during the WRITE cycle aborts the strobe and the shadow update.
        do_reset();
        req_valid = 2'b01; req_data0 = 8'h12;
        cycle();
        req_valid = 2'b00; reset = 1'b1;
        cycle();
        chk("abort_cs_in_write", {31'd0, s_cs}, 32'd1);
        chk("abort_wd_in_write", s_wd, 32'h0000_3CA4);
        reset = 1'b0;
        cycle();
        chk("abort_cs",     {31'd0, s_cs}, 32'd0);
        chk("abort_wn",     {31'd0, s_wn}, 32'd1);
        chk("abort_shadow", {18'd0, s_shadow}, 32'h0000_3FFF);

        // BLANK_CYCLES=0 instance: no writes over 1000 idle cycles.
        do_reset();
        req_valid = 2'b01; req_data0 = 8'h67;
        cycle();
        req_valid = 2'b00;
        cycle();
        zc = 0;
        for (int k = 0; k < 1000; k++) begin
            cycle();
            if (s_zcs) zc++;
        end
        chk("b0_no_writes", zc, 32'd0);
        chk("b0_shadow", {18'd0, z_seg_shadow}, 32'h0000_0178);

        // Randomized traffic with busy, sparse and very sparse phases.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            case ((k / 500) % 3)
                0:       p = 500;
                1:       p = 50;
                default: p = 5;
            endcase
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] && ($urandom_range(999) < p)) begin
                    req_valid[i] = 1'b1;
                    if (i == 0) req_data0 = 8'($urandom);
                    else        req_data1 = 8'($urandom);
                end
            end
            reset = ($urandom_range(399) == 0);
            cycle();
            for (int i = 0; i < 2; i++) begin
                if (s_ready[i]) req_valid[i] = 1'b0;
            end
        end
        reset = 1'b0; req_valid = 2'b00;
        repeat (3) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
